// File: rtl/kalman_pkg.sv
// kalman_pkg: word format, FSM state type, matrix index helper and the
// default diagonal process-noise constants shared by the Kalman datapath.
package kalman_pkg;

  localparam int N     = 32;
  localparam int Q     = 18;
  localparam int SF    = 1 << Q;
  localparam int ACC_W = 2 * N + 2;

  // Real-valued process noise for ialpha, ibeta, omega, theta.
  localparam real QN0_R = 0.01;
  localparam real QN1_R = 0.01;
  localparam real QN2_R = 0.1;
  localparam real QN3_R = 0.001;

  typedef enum logic [1:0] {
    IDLE,
    MUL1,
    MUL2,
    DONE
  } state_t;

  // Flat index of element (r,c) in a row-major 4x4 matrix.
  function automatic logic [3:0] IDX(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

  // Real to Q-format conversion, truncating toward zero.
  function automatic logic signed [N-1:0] to_fix(input real x);
    return N'($rtoi(x * SF));
  endfunction

  localparam logic signed [N-1:0] QN_FIX [4] = '{
    to_fix(QN0_R), to_fix(QN1_R), to_fix(QN2_R), to_fix(QN3_R)
  };

endpackage

// File: rtl/mac_q.sv
// mac_q: signed NxN multiply with a (2N+2)-bit accumulator. On the
// finalize cycle the running sum (including the current product) is
// floor-shifted by Q and saturated to N bits.
module mac_q
  import kalman_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clear,
  input  logic                finalize,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] result,
  output logic                sat
);

  localparam int SW = ACC_W - Q;
  localparam logic signed [SW-1:0] MAX_V = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] base;
  logic signed [SW-1:0]    shifted;
  logic                    too_hi;
  logic                    too_lo;

  // Product, accumulate (clear restarts the sum) and the shifted/saturated view.
  always_comb begin
    prod    = (2*N)'(a) * (2*N)'(b);
    base    = clear ? '0 : acc_q;
    acc_d   = base + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
    shifted = acc_d[ACC_W-1:Q];
    too_hi  = shifted > MAX_V;
    too_lo  = shifted < MIN_V;
    sat     = finalize & (too_hi | too_lo);
    if (too_hi) begin
      result = MAX_V[N-1:0];
    end else if (too_lo) begin
      result = MIN_V[N-1:0];
    end else begin
      result = shifted[N-1:0];
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/covariance_predict.sv
// covariance_predict: P- = F*P*F' + Qn using one shared MAC, one product
// per cycle. Build option COV_SYMM_EN computes only the upper triangle of
// the second product and mirrors it, giving an exactly symmetric result.
module covariance_predict
  import kalman_pkg::*;
#(
  parameter logic signed [N-1:0] QN0 = QN_FIX[0],
  parameter logic signed [N-1:0] QN1 = QN_FIX[1],
  parameter logic signed [N-1:0] QN2 = QN_FIX[2],
  parameter logic signed [N-1:0] QN3 = QN_FIX[3]
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [16*N-1:0] F,
  input  logic [16*N-1:0] P_in,
  output logic [16*N-1:0] P_out,
  output logic            busy,
  output logic            done,
  output logic            overflow
);

  localparam logic signed [N-1:0] QN_K [4] = '{QN0, QN1, QN2, QN3};

  state_t              state_q;
  logic [1:0]          row_q;
  logic [1:0]          col_q;
  logic [1:0]          k_q;
  logic signed [N-1:0] f_q     [16];
  logic signed [N-1:0] p_q     [16];
  logic signed [N-1:0] t_q     [16];
  logic signed [N-1:0] r_q     [16];
  logic signed [N-1:0] p_out_q [16];
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;

  logic signed [N-1:0] mac_a;
  logic signed [N-1:0] mac_b;
  logic signed [N-1:0] mac_res;
  logic signed [N-1:0] qn_sel;
  logic signed [N-1:0] r_val;
  logic [N:0]          qn_sum;
  logic                mac_en;
  logic                mac_clear;
  logic                mac_fin;
  logic                mac_sat;
  logic                qn_sat;
  logic                elem_last;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pack
      assign P_out[gi*N +: N] = p_out_q[gi];
    end
  endgenerate

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

  mac_q u_mac (
    .clk      (clk),
    .reset    (reset),
    .en       (mac_en),
    .clear    (mac_clear),
    .finalize (mac_fin),
    .a        (mac_a),
    .b        (mac_b),
    .result   (mac_res),
    .sat      (mac_sat)
  );

  // Operand selection: F*P in MUL1, T*F' (F read transposed) in MUL2; diagonal Qn add.
  always_comb begin
    mac_en    = (state_q == MUL1) || (state_q == MUL2);
    mac_clear = (k_q == 2'd0);
    mac_fin   = (k_q == 2'd3);
    if (state_q == MUL2) begin
      mac_a = t_q[IDX(row_q, k_q)];
      mac_b = f_q[IDX(col_q, k_q)];
    end else begin
      mac_a = f_q[IDX(row_q, k_q)];
      mac_b = p_q[IDX(k_q, col_q)];
    end
    qn_sel    = ((state_q == MUL2) && (row_q == col_q)) ? QN_K[row_q] : '0;
    qn_sum    = {mac_res[N-1], mac_res} + {qn_sel[N-1], qn_sel};
    qn_sat    = qn_sum[N] ^ qn_sum[N-1];
    if (qn_sat) begin
      r_val = qn_sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      r_val = qn_sum[N-1:0];
    end
    elem_last = (row_q == 2'd3) && (col_q == 2'd3);
  end

  // Sequencer: latches operands, walks both products element by element, publishes the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        f_q[i]     <= '0;
        p_q[i]     <= '0;
        t_q[i]     <= '0;
        r_q[i]     <= '0;
        p_out_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            for (int i = 0; i < 16; i++) begin
              f_q[i] <= F[i*N +: N];
              p_q[i] <= P_in[i*N +: N];
            end
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            state_q <= MUL1;
          end
        end
        MUL1: begin
          k_q <= k_q + 2'd1;
          if (mac_fin) begin
            t_q[IDX(row_q, col_q)] <= mac_res;
            if (mac_sat) ovf_q <= 1'b1;
            if (col_q == 2'd3) begin
              col_q <= '0;
              row_q <= row_q + 2'd1;
              if (elem_last) state_q <= MUL2;
            end else begin
              col_q <= col_q + 2'd1;
            end
          end
        end
        MUL2: begin
          k_q <= k_q + 2'd1;
          if (mac_fin) begin
            r_q[IDX(row_q, col_q)] <= r_val;
`ifdef COV_SYMM_EN
            r_q[IDX(col_q, row_q)] <= r_val;
`endif
            if (mac_sat || qn_sat) ovf_q <= 1'b1;
            if (col_q == 2'd3) begin
`ifdef COV_SYMM_EN
              col_q <= row_q + 2'd1;
`else
              col_q <= '0;
`endif
              row_q <= row_q + 2'd1;
              if (elem_last) state_q <= DONE;
            end else begin
              col_q <= col_q + 2'd1;
            end
          end
        end
        DONE: begin
          for (int i = 0; i < 16; i++) begin
            p_out_q[i] <= r_q[i];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_covariance_predict.sv
// tb_covariance_predict: randomized and directed stimulus; expected results
// come from a plain-arithmetic matrix model and are queued, and a monitor
// compares them whenever done pulses.
module tb_covariance_predict;

  localparam int Q   = 18;
  localparam int SFV = 262144;
`ifdef COV_SYMM_EN
  localparam bit SYMM = 1'b1;
  localparam int LAT  = 105;
`else
  localparam bit SYMM = 1'b0;
  localparam int LAT  = 129;
`endif
  localparam int QNV [4] = '{2621, 2621, 26214, 262};
  localparam logic signed [127:0] MAXW = 128'sd2147483647;
  localparam logic signed [127:0] MINW = -MAXW - 128'sd1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [511:0] F_s = '0;
  logic [511:0] P_s = '0;
  logic [511:0] P_out;
  logic         busy;
  logic         done;
  logic         overflow;

  covariance_predict u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .F        (F_s),
    .P_in     (P_s),
    .P_out    (P_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int tid   = 0;

  typedef struct {
    logic [511:0] r;
    bit           ov;
    int           cyc;
    int           id;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic signed [127:0] el(input logic [511:0] m, input int r, input int c);
    logic signed [31:0] v;
    v = m[(4*r+c)*32 +: 32];
    return 128'(v);
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [127:0] v, output bit s);
    s = 1'b0;
    if (v > MAXW) begin s = 1'b1; return 32'h7fffffff; end
    if (v < MINW) begin s = 1'b1; return 32'h80000000; end
    return v[31:0];
  endfunction

  // Reference: T = sat(F*P), R = sat(T*F') (+ Qn on the diagonal), floor shifts by Q.
  function automatic void model(input logic [511:0] f, input logic [511:0] p,
                                output logic [511:0] r, output bit ov);
    logic signed [127:0] t [16];
    logic signed [127:0] acc;
    logic signed [31:0]  v;
    bit                  s;
    ov = 1'b0;
    r  = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc = acc + el(f, i, k) * el(p, k, j);
        v = sat32(acc >>> Q, s);
        ov |= s;
        t[4*i+j] = 128'(v);
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (SYMM && j < i) continue;
        acc = 0;
        for (int k = 0; k < 4; k++) acc = acc + t[4*i+k] * el(f, j, k);
        v = sat32(acc >>> Q, s);
        ov |= s;
        if (i == j) begin
          v = sat32(128'(v) + 128'(QNV[i]), s);
          ov |= s;
        end
        r[(4*i+j)*32 +: 32] = v;
        if (SYMM) r[(4*j+i)*32 +: 32] = v;
      end
  endfunction

  function automatic logic [511:0] diag(input logic [31:0] v);
    logic [511:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[(5*i)*32 +: 32] = v;
    return m;
  endfunction

  function automatic logic [511:0] transpose(input logic [511:0] m);
    logic [511:0] t;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) t[(4*j+i)*32 +: 32] = m[(4*i+j)*32 +: 32];
    return t;
  endfunction

  function automatic logic [511:0] rand_mat(input int span, input bit symm);
    logic [511:0] m;
    logic [31:0]  v;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (span == 0) v = $urandom;
        else v = 32'(int'($urandom_range(0, 2 * span)) - span);
        m[(4*i+j)*32 +: 32] = v;
      end
    if (symm)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < i; j++) m[(4*i+j)*32 +: 32] = m[(4*j+i)*32 +: 32];
    return m;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: on every done pulse pop the oldest expectation and compare.
  bit   prev_done = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (reset && done === 1'b1) begin
      check("done_width", {511'b0, prev_done}, 512'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done at cycle %0d, required no done", cyc);
      end else begin
        e = exp_q.pop_front();
        check("p_out", P_out, e.r);
        check("overflow", {511'b0, overflow}, {511'b0, e.ov});
        check("latency", 512'(cyc), 512'(e.cyc));
`ifdef COV_SYMM_EN
        check("symmetry", P_out, transpose(P_out));
`endif
        $display("[TB] txn %0d: done at cycle %0d, overflow=%0b, P00=%0d", e.id, cyc,
                 overflow, $signed(P_out[31:0]));
      end
    end
    prev_done <= (done === 1'b1);
  end

  // Drive one start pulse once idle; optionally queue its expected result.
  task automatic issue(input logic [511:0] f, input logic [511:0] p, input bit expect_it);
    int           w;
    logic [511:0] r;
    bit           ov;
    w = 0;
    while (busy !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) begin
      tests++;
      fails++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, w);
    end
    F_s   = f;
    P_s   = p;
    start = 1'b1;
    if (expect_it) begin
      model(f, p, r, ov);
      exp_q.push_back('{r: r, ov: ov, cyc: cyc + 1 + LAT, id: tid});
      tid++;
    end
    @(negedge clk);
    start = 1'b0;
    F_s   = {16{$urandom}};
    P_s   = {16{$urandom}};
    check("busy_after_start", {511'b0, busy}, {511'b0, 1'b1});
  endtask

  logic [511:0] f_sym;
  int           w;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_p_out", P_out, '0);
    check("rst_busy", {511'b0, busy}, '0);
    check("rst_done", {511'b0, done}, '0);
    check("rst_overflow", {511'b0, overflow}, '0);
    reset = 1'b1;
    @(negedge clk);

    issue(diag(SFV), diag(SFV), 1'b1);
    issue(diag(SFV), '0, 1'b1);
    issue(diag(131072), diag(1048576), 1'b1);
    issue(diag(26214400), diag(26214400), 1'b1);
    issue(diag(SFV), diag(SFV), 1'b1);

    f_sym = diag(SFV);
    f_sym[(4*0+2)*32 +: 32] = 32'd65536;
    f_sym[(4*1+3)*32 +: 32] = -32'sd32768;
    f_sym[(4*3+2)*32 +: 32] = 32'd3;
    issue(f_sym, rand_mat(4 * SFV, 1'b1), 1'b1);

    for (int n = 0; n < 4; n++) issue(rand_mat(SFV, 1'b0), rand_mat(4 * SFV, 1'b1), 1'b1);
    for (int n = 0; n < 2; n++) issue(rand_mat(0, 1'b0), rand_mat(0, 1'b0), 1'b1);

    // start pulsed during MUL1 must be ignored
    issue(rand_mat(SFV, 1'b0), rand_mat(SFV, 1'b1), 1'b1);
    repeat (5) @(negedge clk);
    F_s   = diag(26214400);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // reset in the middle of MUL2 discards the computation
    issue(rand_mat(SFV, 1'b0), rand_mat(SFV, 1'b1), 1'b0);
    repeat (74) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", {511'b0, busy}, '0);
    check("midrst_done", {511'b0, done}, '0);
    check("midrst_p_out", P_out, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(diag(SFV), diag(SFV), 1'b1);

    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (150) @(negedge clk);
    check("queue_empty", 512'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
